// File: rtl/flex_uart_pkg.sv
// Shared types, line constants and the parity helper for the buffered UART transmitter.
package flex_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam int   MIN_DATA_BITS = 5;
  localparam int   MAX_DATA_BITS = 9;

  // XOR over the low n bits; odd parity inverts the result.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic [3:0]               n,
                                       input logic                     odd);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++)
      if (i < int'(n)) p = p ^ data[i];
    return p ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO; power-of-two depth so pointers wrap naturally.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/flex_uart_tx.sv
// Buffered UART framer: configurable data length, parity and stop bits, back-to-back frames.
module flex_uart_tx
  import flex_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_data_valid,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_ready,
  input  logic [3:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  output logic                          tx_serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int             TW        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]     DW4       = 4'(DATA_WIDTH);

  tx_state_e              state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [3:0]             bit_q, bit_d;
  logic [3:0]             n_q, n_cfg;
  logic                   par_en_q, stop2_q, par_bit_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic                   tx_q, tx_d;
  logic                   tick_last, pop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_rdata;

  uart_tx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_data_valid),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_data_ready = ~fifo_full;
  assign tick_last     = (tick_q == TICK_LAST);
  assign n_cfg = (cfg_data_bits < 4'(MIN_DATA_BITS) || cfg_data_bits > DW4) ? DW4 : cfg_data_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_last ? '0 : tick_q + TW'(1);
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!fifo_empty) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START:  if (tick_last) state_d = DATA;
      DATA: if (tick_last) begin
        if (bit_q == n_q - 4'd1) state_d = par_en_q ? PARITY : STOP;
        else                     bit_d   = bit_q + 4'd1;
      end
      PARITY: if (tick_last) state_d = STOP;
      STOP: if (tick_last) begin
        if (!stop2_q || bit_q == 4'd1) begin
          // Chain straight into the next start bit when a word is waiting.
          if (!fifo_empty) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      tick_d = '0;
      bit_d  = '0;
    end
  end

  // Config and word are latched together on the pop that starts each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      n_q       <= DW4;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (pop) begin
      shift_q   <= fifo_rdata;
      n_q       <= n_cfg;
      par_en_q  <= cfg_parity_en;
      stop2_q   <= cfg_stop2;
      par_bit_q <= parity_calc(MAX_DATA_BITS'(fifo_rdata), n_cfg, cfg_parity_odd);
    end else if (state_q == DATA && tick_last) begin
      shift_q   <= shift_q >> 1;
    end
  end

  always_comb begin
    tx_d = STOP_BIT;
    case (state_q)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = STOP_BIT;
    endcase
  end

  assign tx_serial_out = tx_q;
  assign tx_busy       = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_flex_uart_tx.sv
// Self-checking bench: hand-derived frame table, random frames against a string-level frame model.
module tb_flex_uart_tx;

  localparam int OS = 16;

  logic       clk, rst_n;
  logic       tx_data_valid, tx_data_ready;
  logic [7:0] tx_data;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en, cfg_parity_odd, cfg_stop2;
  logic       tx_serial_out, tx_busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  flex_uart_tx #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data_valid  (tx_data_valid),
    .tx_data        (tx_data),
    .tx_data_ready  (tx_data_ready),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .tx_serial_out  (tx_serial_out),
    .tx_busy        (tx_busy),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] bits;
    logic       pen, podd, s2;
    string      line;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Line pattern of one frame as '0'/'1' characters in transmit order.
  function automatic string frame_str(input logic [7:0] d, input int bits,
                                      input bit pen, input bit podd, input bit s2);
    string s = "0";
    int n = (bits < 5 || bits > 8) ? 8 : bits;
    int ones = 0;
    for (int i = 0; i < n; i++) begin
      s = {s, d[i] ? "1" : "0"};
      ones += int'(d[i]);
    end
    if (pen) s = {s, (((ones % 2) == 1) != podd) ? "1" : "0"};
    s = {s, s2 ? "11" : "1"};
    return s;
  endfunction

  task automatic set_cfg(input logic [3:0] b, input logic pen, input logic podd, input logic s2);
    cfg_data_bits = b; cfg_parity_en = pen; cfg_parity_odd = podd; cfg_stop2 = s2;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_data_valid = 1'b1;
    @(posedge clk);
    #1 tx_data_valid = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_serial_out !== 1'b0 && n < 2000);
    chk({nm, " start seen"}, int'(tx_serial_out), 0);
  endtask

  // Caller sits on the negedge of the first start-bit cycle.
  task automatic check_line(input string nm, input string pat);
    int bad = 0, bbad = 0, tot;
    tot = pat.len() * OS;
    for (int c = 0; c < tot; c++) begin
      if (c != 0) @(negedge clk);
      if (tx_serial_out !== (pat[c / OS] == 8'h31)) bad++;
      if (tx_busy !== (c != tot - 1)) bbad++;
    end
    chk({nm, " line"}, bad, 0);
    chk({nm, " busy"}, bbad, 0);
  endtask

  int rdy_bad, max_cnt, full_seen;
  logic [7:0] bw[6];

  initial begin
    tbl[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, "0101001011"};
    tbl[1] = '{8'h41, 4'd7,  1'b1, 1'b0, 1'b1, "01000001011"};
    tbl[2] = '{8'hFF, 4'd8,  1'b1, 1'b1, 1'b0, "01111111111"};
    tbl[3] = '{8'hE3, 4'd5,  1'b0, 1'b0, 1'b0, "0110001"};
    tbl[4] = '{8'h5A, 4'd3,  1'b1, 1'b0, 1'b0, "00101101001"};
    tbl[5] = '{8'h2C, 4'd6,  1'b1, 1'b1, 1'b1, "0001101011"};

    rst_n = 1'b0; tx_data_valid = 1'b0; tx_data = '0;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset line", int'(tx_serial_out), 1);
    chk("reset ready", int'(tx_data_ready), 1);
    chk("reset busy", int'(tx_busy), 0);
    chk("reset count", int'(fifo_count), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[t]) begin
      set_cfg(tbl[t].bits, tbl[t].pen, tbl[t].podd, tbl[t].s2);
      push(tbl[t].data);
      @(negedge clk);
      chk($sformatf("tbl%0d count after push", t), int'(fifo_count), 1);
      chk($sformatf("tbl%0d idle before start", t), int'(tx_serial_out), 1);
      @(negedge clk);
      chk($sformatf("tbl%0d count after pop", t), int'(fifo_count), 0);
      chk($sformatf("tbl%0d still high", t), int'(tx_serial_out), 1);
      @(negedge clk);
      check_line($sformatf("tbl%0d", t), tbl[t].line);
      repeat (3) @(negedge clk);
    end

    for (int r = 0; r < 12; r++) begin
      logic [7:0] d;
      logic [3:0] b;
      logic pe, po, s2;
      d = 8'($urandom); b = 4'($urandom_range(0, 15));
      pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom);
      set_cfg(b, pe, po, s2);
      push(d);
      wait_start($sformatf("rnd%0d", r));
      check_line($sformatf("rnd%0d d=%h b=%0d", r, d, b), frame_str(d, int'(b), pe, po, s2));
      repeat (2) @(negedge clk);
    end

    // Stop-bit setting changes after the first frame starts; only the queued frame sees it.
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    push(8'h0F);
    push(8'hF0);
    wait_start("stop2");
    cfg_stop2 = 1'b1;
    check_line("stop2 change", "011110000100000111111");
    cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);

    // Six-word burst into a four-deep FIFO.
    set_cfg(4'd8, 1'b1, 1'b0, 1'b0);
    rdy_bad = 0; max_cnt = 0; full_seen = 0;
    foreach (bw[i]) bw[i] = 8'($urandom);
    begin
      string burst = "";
      foreach (bw[i]) burst = {burst, frame_str(bw[i], 8, 1'b1, 1'b0, 1'b0)};
      fork
        begin
          int idx = 0;
          while (idx < 6) begin
            @(negedge clk);
            tx_data_valid = 1'b1;
            tx_data = bw[idx];
            if (tx_data_ready !== (fifo_count != 3'd4)) rdy_bad++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (!tx_data_ready) full_seen++;
            if (tx_data_ready) idx++;
          end
          @(negedge clk);
          tx_data_valid = 1'b0;
        end
        begin
          wait_start("burst");
          check_line("burst", burst);
        end
      join
    end
    chk("burst ready vs full", rdy_bad, 0);
    chk("burst max count", max_cnt, 4);
    chk("burst full seen", int'(full_seen > 0), 1);
    repeat (3) @(negedge clk);

    // Reset during a data bit with a second word still queued.
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    push(8'h00);
    push(8'h33);
    wait_start("reset frame");
    repeat (40) @(negedge clk);
    chk("pre-reset data bit", int'(tx_serial_out), 0);
    rst_n = 1'b0;
    tx_data_valid = 1'b1;
    tx_data = 8'h77;
    #1;
    chk("async line high", int'(tx_serial_out), 1);
    chk("reset mid count", int'(fifo_count), 0);
    chk("reset mid busy", int'(tx_busy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("handshake ignored in reset", int'(fifo_count), 0);
    tx_data_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset line", int'(tx_serial_out), 1);
    chk("post-reset busy", int'(tx_busy), 0);
    chk("post-reset count", int'(fifo_count), 0);
    push(8'hA5);
    wait_start("post-reset");
    check_line("post-reset frame", "0101001011");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flex_uart_tx.md
# flex_uart_tx

Parametrised UART transmitter: a buffered serial framer with runtime-selectable data length, parity and stop bits. A FIFO buffers host words, so back-to-back frames go out with no idle gap. It sits between the host's ready/valid byte stream and the TX pin, on the same peripheral clock that runs at OVERSAMPLE × baud. It supersedes the fixed 8N1, single-buffer transmitter.

## Interface
- `DATA_WIDTH`, default 8: maximum data bits per frame; legal range 5–9.
- `OVERSAMPLE`, default 16: clk cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: number of buffered words; power of two, ≥ 2.
- `clk` input, 1: peripheral clock.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `tx_data_valid` input, 1: `tx_data` holds a valid word.
- `tx_data` input, DATA_WIDTH: word to send, LSB first.
- `tx_data_ready` output, 1: the FIFO can accept a word this cycle.
- `cfg_data_bits` input, 4: data bits per frame, 5..DATA_WIDTH.
- `cfg_parity_en` input, 1: append a parity bit.
- `cfg_parity_odd` input, 1: 1 selects odd parity, 0 selects even.
- `cfg_stop2` input, 1: 1 selects two stop bits, 0 selects one.
- `tx_serial_out` output, 1: serial line; idles high.
- `tx_busy` output, 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count` output, $clog2(FIFO_DEPTH)+1: number of words currently buffered.

## Operation
- **Handshake:** a word transfers on any rising edge where `tx_data_valid & tx_data_ready`. `tx_data_ready = ~fifo_full`, so it does not depend on `tx_data_valid`.
- **Frame format:** one start bit (0), then `n` data bits LSB first, then an optional parity bit, then 1 or 2 stop bits (1).
  - `n` = `cfg_data_bits`. If `cfg_data_bits` is below 5 or above DATA_WIDTH, `n` clamps to DATA_WIDTH.
  - Data bits at index ≥ `n` are ignored.
  - Parity is XOR of the `n` data bits. Even parity sends XOR; odd parity sends ~XOR.
- **Config sampling:** all `cfg_*` inputs are captured when the start bit begins. Changing them mid-frame has no effect until the next frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty; this pops one word.
  - START → DATA after one bit period.
  - DATA → PARITY (if parity enabled) or STOP after `n` bit periods.
  - PARITY → STOP after one bit period.
  - STOP → START if the FIFO is non-empty at the last cycle of the last stop bit (pops a word). Otherwise STOP → IDLE.
- **Counters:**
  - Tick counter runs 0..OVERSAMPLE-1 and is active in every state except IDLE.
  - Bit counter runs 0..n-1 in DATA, and 0..1 in STOP when two stop bits are selected.
  - Both clear on every state change.
- **Output:** `tx_serial_out` is registered and equals 1 in IDLE.

## Timing
- **Reset values:** `tx_serial_out`=1, `tx_data_ready`=1, `tx_busy`=0, `fifo_count`=0. The FSM goes to IDLE and the FIFO empties.
  - Handshakes while `rst_n` is low are ignored.
  - Asserting reset mid-frame aborts the frame; the line returns high asynchronously.
- **Latency:** a word accepted at edge N into an empty FIFO with the FSM in IDLE pops at edge N+1. The start bit is on `tx_serial_out` from N+2 for exactly OVERSAMPLE cycles.
- **Bit period:** every bit lasts exactly OVERSAMPLE cycles.
- **Frame length:** (1 + n + p + s) × OVERSAMPLE cycles, where p = parity bit (0/1) and s = stop bits (1/2).
- **Back-to-back frames:** the next start bit directly follows the last stop-bit cycle, with zero idle cycles.
- **FIFO boundaries:**
  - Full: `tx_data_ready`=0 and no write.
  - Push and pop on the same edge: `fifo_count` unchanged.
  - Pop only when non-empty.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- **tx_busy:** falls in the same cycle the FSM enters IDLE with the FIFO empty.

## Structure
- **Package `flex_uart_pkg`:** holds
  - the state enum `tx_state_e` (IDLE, START, DATA, PARITY, STOP);
  - the constants START_BIT=0, STOP_BIT=1, MIN_DATA_BITS=5;
  - function `parity_calc(data, n, odd)`.
- **Sub-module `uart_tx_fifo`:** synchronous FIFO, parametrised by WIDTH and DEPTH. It exposes push/pop/full/empty/count and owns the pointer-wrap logic.
- **Top-level `flex_uart_tx`:** contains the FSM, the counters, the config capture register and the shift register.

## Test plan
- 8N1 (cfg_data_bits=8, parity off, one stop bit), OVERSAMPLE=16, send 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles; `tx_busy` drops after 160 cycles.
- 7E2, send 0x41 → 7 data bits 1000001, parity 0, two stop bits; frame is 11 bits (176 cycles).
- 8O1, send 0xFF → parity bit 1; then 5N1 with `tx_data`=0xE3 → only bits 1,1,0,0,0 are sent.
- Write 6 words back-to-back with FIFO_DEPTH=4 → `tx_data_ready` low while the FIFO is full, `fifo_count` never exceeds 4, and all 6 frames go out with zero idle cycles between them.
- Change `cfg_stop2` mid-frame → the current frame is unaffected and the next frame uses the new setting.
- Assert `rst_n` low mid-data-bit → line high immediately; after release `fifo_count`=0, state IDLE, and the next write produces a clean frame.
